// File: rtl/demux_stream_if.sv
// Stream bundle for demux_stream: one tagged input stream and two output channels,
// each with a valid/ready handshake and a fill level.
interface demux_stream_if #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 2
);
    localparam int unsigned LW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] in_data;
    logic             in_sel;
    logic             in_valid;
    logic             in_ready;

    logic [WIDTH-1:0] a_data;
    logic             a_valid;
    logic             a_ready;
    logic [LW-1:0]    a_level;

    logic [WIDTH-1:0] b_data;
    logic             b_valid;
    logic             b_ready;
    logic [LW-1:0]    b_level;

    modport slave (
        input  in_data, in_sel, in_valid, a_ready, b_ready,
        output in_ready, a_data, a_valid, a_level, b_data, b_valid, b_level
    );

    modport master (
        output in_data, in_sel, in_valid, a_ready, b_ready,
        input  in_ready, a_data, a_valid, a_level, b_data, b_valid, b_level
    );
endinterface

// File: rtl/demux_stream.sv
// 1-to-2 stream demultiplexer: in_sel=1 steers a word to channel A, 0 to channel B.
// Each channel is a first-word-fall-through FIFO with its own valid/ready handshake.
module demux_stream #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 2
) (
    input logic           clk,
    input logic           reset_n,
    demux_stream_if.slave bus
);
    localparam int unsigned   PW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned   LW        = $clog2(DEPTH + 1);
    localparam logic [LW-1:0] FullLevel = LW'(DEPTH);

    // Channel index 0 is A, 1 is B.
    logic [1:0]       w_full;
    logic [1:0]       w_push;
    logic [1:0]       w_pop;
    logic [1:0]       w_out_ready;
    logic [WIDTH-1:0] w_head  [2];
    logic [LW-1:0]    w_level [2];
    logic             w_accept;

    assign w_out_ready = {bus.b_ready, bus.a_ready};

    // Fullness is taken before any same-cycle pop, so a full channel always refuses.
    assign bus.in_ready = bus.in_sel ? !w_full[0] : !w_full[1];
    assign w_accept     = bus.in_valid && bus.in_ready;
    assign w_push       = {w_accept && !bus.in_sel, w_accept && bus.in_sel};

    for (genvar c = 0; c < 2; c++) begin : g_ch
        logic [WIDTH-1:0] r_mem [DEPTH];
        logic [PW-1:0]    r_wptr;
        logic [PW-1:0]    r_rptr;
        logic [LW-1:0]    r_level;

        assign w_full[c] = (r_level == FullLevel);
        assign w_pop[c]  = (r_level != '0) && w_out_ready[c];

        always_ff @(posedge clk) begin
            if (!reset_n) begin
                r_mem   <= '{default: '0};
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_level <= '0;
            end else begin
                if (w_push[c]) begin
                    r_mem[r_wptr] <= bus.in_data;
                    r_wptr        <= r_wptr + PW'(1);
                end
                if (w_pop[c]) begin
                    r_rptr <= r_rptr + PW'(1);
                end
                if (w_push[c] && !w_pop[c]) begin
                    r_level <= r_level + LW'(1);
                end else if (w_pop[c] && !w_push[c]) begin
                    r_level <= r_level - LW'(1);
                end
            end
        end

        // Empty channels present zero rather than stale storage.
        assign w_head[c]  = (r_level != '0) ? r_mem[r_rptr] : '0;
        assign w_level[c] = r_level;
    end

    assign bus.a_data  = w_head[0];
    assign bus.a_valid = (w_level[0] != '0);
    assign bus.a_level = w_level[0];
    assign bus.b_data  = w_head[1];
    assign bus.b_valid = (w_level[1] != '0);
    assign bus.b_level = w_level[1];
endmodule

// File: tb/tb_demux_stream.sv
// Self-checking bench for demux_stream: queue-based channel model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic with resets.
module tb_demux_stream;
    localparam int unsigned WIDTH = 4;
    localparam int unsigned DEPTH = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    demux_stream_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    demux_stream #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    logic [WIDTH-1:0] qa[$];
    logic [WIDTH-1:0] qb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: each channel is a bounded queue; full is judged before popping.
    always @(posedge clk) begin : model
        bit pa, pb, rdy;
        if (!reset_n) begin
            qa.delete();
            qb.delete();
        end else begin
            rdy = bus.in_sel ? (qa.size() < DEPTH) : (qb.size() < DEPTH);
            pa  = (qa.size() != 0) && bus.a_ready;
            pb  = (qb.size() != 0) && bus.b_ready;
            if (pa) void'(qa.pop_front());
            if (pb) void'(qb.pop_front());
            if (bus.in_valid && rdy) begin
                if (bus.in_sel) qa.push_back(bus.in_data);
                else            qb.push_back(bus.in_data);
            end
        end
    end

    always @(negedge clk) begin : compare
        if (chk_en) begin
            chk("a_valid",  32'(bus.a_valid), 32'(qa.size() != 0));
            chk("a_data",   32'(bus.a_data),  (qa.size() != 0) ? 32'(qa[0]) : 32'd0);
            chk("a_level",  32'(bus.a_level), 32'(qa.size()));
            chk("b_valid",  32'(bus.b_valid), 32'(qb.size() != 0));
            chk("b_data",   32'(bus.b_data),  (qb.size() != 0) ? 32'(qb[0]) : 32'd0);
            chk("b_level",  32'(bus.b_level), 32'(qb.size()));
            chk("in_ready", 32'(bus.in_ready),
                bus.in_sel ? 32'(qa.size() < DEPTH) : 32'(qb.size() < DEPTH));
        end
    end

    // Drive one cycle's inputs just after the edge; return just after the following negedge.
    task automatic cyc(input bit v, input bit s, input logic [3:0] d,
                       input bit ar, input bit br, input bit rn);
        @(posedge clk);
        #1;
        bus.in_valid = v;
        bus.in_sel   = s;
        bus.in_data  = d;
        bus.a_ready  = ar;
        bus.b_ready  = br;
        reset_n      = rn;
        @(negedge clk);
        #1;
    endtask

    initial begin : stim
        bit v, s, ar, br, rn, hold;
        logic [3:0] d;

        bus.in_valid = 1'b0;
        bus.in_sel   = 1'b0;
        bus.in_data  = '0;
        bus.a_ready  = 1'b0;
        bus.b_ready  = 1'b0;

        // Reset then idle
        cyc(0, 0, 4'h0, 0, 0, 0);
        cyc(0, 0, 4'h0, 0, 0, 0);
        chk_en = 1'b1;
        chk("rst a_valid", 32'(bus.a_valid), 32'd0);
        chk("rst b_valid", 32'(bus.b_valid), 32'd0);
        chk("rst a_data",  32'(bus.a_data),  32'd0);
        chk("rst b_data",  32'(bus.b_data),  32'd0);
        chk("rst a_level", 32'(bus.a_level), 32'd0);
        chk("rst b_level", 32'(bus.b_level), 32'd0);
        chk("rst in_ready", 32'(bus.in_ready), 32'd1);

        // Basic steer
        cyc(1, 1, 4'hA, 1, 1, 1);
        cyc(1, 0, 4'h5, 1, 1, 1);
        chk("steer a_valid", 32'(bus.a_valid), 32'd1);
        chk("steer a_data",  32'(bus.a_data),  32'hA);
        cyc(0, 0, 4'h0, 1, 1, 1);
        chk("steer b_data",  32'(bus.b_data),  32'h5);
        chk("steer a_empty", 32'(bus.a_valid), 32'd0);
        cyc(0, 0, 4'h0, 1, 1, 1);
        chk("steer b_empty", 32'(bus.b_valid), 32'd0);

        // Fill and backpressure
        cyc(1, 1, 4'h1, 0, 1, 1);
        cyc(1, 1, 4'h2, 0, 1, 1);
        cyc(1, 1, 4'h3, 0, 1, 1);
        chk("fill a_level",  32'(bus.a_level),  32'd2);
        chk("fill in_ready", 32'(bus.in_ready), 32'd0);
        cyc(1, 1, 4'h3, 1, 1, 1);
        chk("fill pop1 data",  32'(bus.a_data),   32'h1);
        chk("fill no same-cycle accept", 32'(bus.in_ready), 32'd0);
        cyc(1, 1, 4'h3, 1, 1, 1);
        chk("fill pop2 data",  32'(bus.a_data),   32'h2);
        chk("fill ready again", 32'(bus.in_ready), 32'd1);
        cyc(0, 1, 4'h0, 1, 1, 1);
        chk("fill word3", 32'(bus.a_data), 32'h3);
        cyc(0, 1, 4'h0, 1, 1, 1);
        chk("fill drained", 32'(bus.a_level), 32'd0);

        // Head-of-line block
        cyc(1, 1, 4'h7, 0, 0, 1);
        cyc(1, 1, 4'h8, 0, 0, 1);
        cyc(1, 0, 4'hC, 0, 0, 1);
        chk("hol b ready", 32'(bus.in_ready), 32'd1);
        cyc(1, 1, 4'hD, 0, 0, 1);
        chk("hol a blocked", 32'(bus.in_ready), 32'd0);
        chk("hol b_data",    32'(bus.b_data),   32'hC);
        cyc(1, 1, 4'hD, 1, 0, 1);
        chk("hol a head",    32'(bus.a_data),   32'h7);
        chk("hol still blocked", 32'(bus.in_ready), 32'd0);
        cyc(1, 1, 4'hD, 0, 0, 1);
        chk("hol unblocked", 32'(bus.in_ready), 32'd1);
        cyc(0, 1, 4'h0, 0, 0, 1);
        chk("hol a_level", 32'(bus.a_level), 32'd2);
        for (int i = 0; i < 4; i++) cyc(0, 0, 4'h0, 1, 1, 1);
        chk("hol drained", 32'(bus.a_level), 32'd0);

        // Concurrent push/pop with pointer wrap
        for (int i = 0; i < 8; i++) begin
            cyc(1, 1, 4'(i), 1, 1, 1);
            if (i > 0) begin
                chk("wrap a_level", 32'(bus.a_level), 32'd1);
                chk("wrap a_data",  32'(bus.a_data),  32'(i - 1));
            end
        end
        cyc(0, 1, 4'h0, 1, 1, 1);
        chk("wrap last", 32'(bus.a_data), 32'h7);
        cyc(0, 1, 4'h0, 1, 1, 1);

        // Reset mid-operation
        cyc(1, 1, 4'h9, 0, 0, 1);
        cyc(1, 1, 4'hA, 0, 0, 1);
        cyc(1, 0, 4'hB, 0, 0, 1);
        cyc(0, 0, 4'h0, 0, 0, 1);
        chk("mid a_level", 32'(bus.a_level), 32'd2);
        chk("mid b_level", 32'(bus.b_level), 32'd1);
        cyc(1, 0, 4'hF, 1, 1, 0);
        cyc(0, 0, 4'h0, 0, 0, 1);
        chk("mid rst a_level", 32'(bus.a_level), 32'd0);
        chk("mid rst b_level", 32'(bus.b_level), 32'd0);
        chk("mid rst b_data",  32'(bus.b_data),  32'd0);
        chk("mid rst a_valid", 32'(bus.a_valid), 32'd0);
        cyc(1, 0, 4'hE, 0, 0, 1);
        cyc(0, 0, 4'h0, 0, 0, 1);
        chk("post rst b_data", 32'(bus.b_data), 32'hE);
        cyc(0, 0, 4'h0, 1, 1, 1);

        // Randomized traffic; a stalled word is held until accepted
        hold = 1'b0;
        v = 1'b0;
        s = 1'b0;
        d = '0;
        for (int n = 0; n < 3000; n++) begin
            if (!hold) begin
                v = ($urandom_range(0, 3) != 0);
                s = 1'($urandom_range(0, 1));
                d = 4'($urandom);
            end
            ar = ($urandom_range(0, 2) != 0);
            br = ($urandom_range(0, 3) == 0);
            if (n % 500 > 250) br = ($urandom_range(0, 3) != 0);
            rn = ($urandom_range(0, 199) != 0);
            cyc(v, s, d, ar, br, rn);
            hold = v && rn && !(s ? (qa.size() < DEPTH) : (qb.size() < DEPTH));
        end
        for (int i = 0; i < 4; i++) cyc(0, 0, 4'h0, 1, 1, 1);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
